// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Brief    : Multi-cycle LSB-first subtractor, diff = a - b - bin.
//             BPC bits are resolved per clock through a ripple of
//             full-subtractor cells; the borrow is registered between chunks.
//             Start/done handshake with borrow-out, signed-overflow and zero
//             flags.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_cycles = WIDTH / BPC;
    localparam int c_cntw   = (c_cycles > 1) ? $clog2(c_cycles) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_res;
    logic                r_br;
    logic                r_a_msb;
    logic                r_b_msb;
    logic [c_cntw-1:0]   r_cnt;

    logic [BPC:0]        w_br;
    logic [BPC-1:0]      w_d;
    logic [WIDTH-1:0]    w_a_next;
    logic [WIDTH-1:0]    w_b_next;
    logic [WIDTH-1:0]    w_res_next;
    logic                w_last;

    // Borrow chain enters the chunk from the registered borrow of the previous chunk
    assign w_br[0] = r_br;

    // One full-subtractor cell per bit of the chunk, borrow ripples LSB to MSB
    generate
        for (genvar i = 0; i < BPC; i++) begin : g_cell
            assign w_d[i]      = r_a[i] ^ r_b[i] ^ w_br[i];
            assign w_br[i + 1] = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & w_br[i]);
        end
    endgenerate

    // Next operand/result values; a full-width chunk needs no shifting at all
    generate
        if (BPC == WIDTH) begin : g_single
            assign w_res_next = w_d;
            assign w_a_next   = '0;
            assign w_b_next   = '0;
        end else begin : g_multi
            assign w_res_next = {w_d, r_res[WIDTH-1:BPC]};
            assign w_a_next   = {{BPC{1'b0}}, r_a[WIDTH-1:BPC]};
            assign w_b_next   = {{BPC{1'b0}}, r_b[WIDTH-1:BPC]};
        end
    endgenerate

    assign w_last = (r_cnt == c_cntw'(c_cycles - 1));

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        // MSBs are kept aside because the shift registers lose them
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_cnt   <= '0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_a   <= w_a_next;
                    r_b   <= w_b_next;
                    r_res <= w_res_next;
                    r_br  <= w_br[BPC];
                    r_cnt <= r_cnt + c_cntw'(1);
                    if (w_last) begin
                        diff    <= w_res_next;
                        bout    <= w_br[BPC];
                        ovf     <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
                        zero    <= ~|w_res_next;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Brief    : Self-checking bench for serial_subtractor, three instances with
//             WIDTH=8 and BPC = 1, 4, 8. Expected results come from an
//             arithmetic reference model and are queued on each start.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic       z;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start  [3];
    logic [7:0] a_in   [3];
    logic [7:0] b_in   [3];
    logic       bin_in [3];
    logic       ready_o[3];
    logic       busy_o [3];
    logic       done_o [3];
    logic [7:0] diff_o [3];
    logic       bout_o [3];
    logic       ovf_o  [3];
    logic       zero_o [3];

    exp_t       sb[$];
    int         tests  = 0;
    int         failed = 0;
    logic [7:0] last_d;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .BPC(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[0]), .a(a_in[0]), .b(b_in[0]), .bin(bin_in[0]),
        .ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]), .diff(diff_o[0]),
        .bout(bout_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0])
    );

    serial_subtractor #(.WIDTH(8), .BPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start[1]), .a(a_in[1]), .b(b_in[1]), .bin(bin_in[1]),
        .ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]), .diff(diff_o[1]),
        .bout(bout_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1])
    );

    serial_subtractor #(.WIDTH(8), .BPC(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start[2]), .a(a_in[2]), .b(b_in[2]), .bin(bin_in[2]),
        .ready(ready_o[2]), .busy(busy_o[2]), .done(done_o[2]), .diff(diff_o[2]),
        .bout(bout_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2])
    );

    // Reference: 9-bit arithmetic difference, bit 8 is the borrow out
    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        exp_t       r;
        logic [8:0] full;
        full = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
        r.d  = full[7:0];
        r.bo = full[8];
        r.ov = (av[7] != bv[7]) && (full[7] != av[7]);
        r.z  = (full[7:0] == 8'd0);
        return r;
    endfunction

    function automatic int lat_exp(input int sel);
        case (sel)
            0:       return 8;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    // Pulse start for one edge, queue the expectation, then scramble the inputs
    task automatic drive_start(input int sel, input logic [7:0] av, input logic [7:0] bv, input logic bi);
        @(negedge clk);
        a_in[sel]   = av;
        b_in[sel]   = bv;
        bin_in[sel] = bi;
        start[sel]  = 1'b1;
        sb.push_back(model(av, bv, bi));
        @(negedge clk);
        start[sel]  = 1'b0;
        a_in[sel]   = 8'($urandom);
        b_in[sel]   = 8'($urandom);
        bin_in[sel] = 1'($urandom);
    endtask

    // Counts negedges after the start edge until done is seen (bounded)
    task automatic wait_done(input int sel, input int budget, output int lat);
        lat = 0;
        while (done_o[sel] !== 1'b1 && lat <= budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            start[s] = 1'b0; a_in[s] = '0; b_in[s] = '0; bin_in[s] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            tests++;
            if ({ready_o[s], busy_o[s], done_o[s], diff_o[s], bout_o[s], ovf_o[s], zero_o[s]}
                    !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
                failed++;
                $display("FAIL reset[%0d]: got rdy=%b busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b, exp 1 0 0 00 0 0 0",
                         s, ready_o[s], busy_o[s], done_o[s], diff_o[s], bout_o[s], ovf_o[s], zero_o[s]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] va [7] = '{8'h05, 8'h03, 8'h00, 8'h2A, 8'h80, 8'h7F, 8'hFF};
        logic [7:0] vb [7] = '{8'h03, 8'h05, 8'h00, 8'h2A, 8'h01, 8'hFF, 8'h01};
        logic       vi [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_t e;
        int   lat;
        for (int n = 0; n < 7; n++) begin
            drive_start(0, va[n], vb[n], vi[n]);
            wait_done(0, 20, lat);
            tests++;
            if (lat != 8) begin
                failed++;
                $display("FAIL basic_latency[%0d]: got %0d cycles, exp 8", n, lat);
            end
            e = sb.pop_front();
            tests++;
            if ({diff_o[0], bout_o[0], ovf_o[0], zero_o[0]} !== {e.d, e.bo, e.ov, e.z}) begin
                failed++;
                $display("FAIL basic_result[%0d]: got diff=%h bout=%b ovf=%b zero=%b, exp diff=%h bout=%b ovf=%b zero=%b",
                         n, diff_o[0], bout_o[0], ovf_o[0], zero_o[0], e.d, e.bo, e.ov, e.z);
            end
            last_d = e.d;
        end
    endtask

    task automatic test_handshake();
        exp_t e;
        int   ndone    = 0;
        int   done_cyc = -1;
        drive_start(0, 8'h05, 8'h03, 1'b0);
        e = sb.pop_front();
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                tests++;
                if (diff_o[0] !== last_d || busy_o[0] !== 1'b1 || ready_o[0] !== 1'b0) begin
                    failed++;
                    $display("FAIL hs_hold: got diff=%h busy=%b ready=%b, exp diff=%h busy=1 ready=0",
                             diff_o[0], busy_o[0], ready_o[0], last_d);
                end
            end
            if (done_o[0] === 1'b1) begin
                ndone++;
                done_cyc = cyc;
                tests++;
                if ({diff_o[0], bout_o[0], ovf_o[0], zero_o[0]} !== {e.d, e.bo, e.ov, e.z}) begin
                    failed++;
                    $display("FAIL hs_result: got diff=%h bout=%b ovf=%b zero=%b, exp diff=%h bout=%b ovf=%b zero=%b",
                             diff_o[0], bout_o[0], ovf_o[0], zero_o[0], e.d, e.bo, e.ov, e.z);
                end
            end
            if (cyc == 9) begin
                tests++;
                if (ready_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
                    failed++;
                    $display("FAIL hs_ready_after_done: got ready=%b busy=%b, exp ready=1 busy=0", ready_o[0], busy_o[0]);
                end
            end
            // Start pulses while busy: one mid-SHIFT, one sampled in DONE
            start[0] = (cyc == 3 || cyc == 8);
        end
        start[0] = 1'b0;
        tests++;
        if (ndone != 1 || done_cyc != 8) begin
            failed++;
            $display("FAIL hs_done_count: got %0d pulses first at cycle %0d, exp 1 pulse at cycle 8", ndone, done_cyc);
        end
        tests++;
        if (ready_o[0] !== 1'b1 || busy_o[0] !== 1'b0) begin
            failed++;
            $display("FAIL hs_idle_end: got ready=%b busy=%b, exp ready=1 busy=0", ready_o[0], busy_o[0]);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        int   ndone = 0;
        drive_start(0, 8'hA5, 8'h11, 1'b0);
        e = sb.pop_back();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if ({ready_o[0], busy_o[0], done_o[0], diff_o[0], bout_o[0], ovf_o[0], zero_o[0]}
                !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL abort_outputs: got rdy=%b busy=%b done=%b diff=%h bout=%b ovf=%b zero=%b, exp 1 0 0 00 0 0 0",
                     ready_o[0], busy_o[0], done_o[0], diff_o[0], bout_o[0], ovf_o[0], zero_o[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done_o[0] === 1'b1) ndone++;
        end
        tests++;
        if (ndone != 0) begin
            failed++;
            $display("FAIL abort_no_done: got %0d done pulses, exp 0", ndone);
        end
        drive_start(0, 8'h10, 8'h01, 1'b0);
        wait_done(0, 20, lat);
        e = sb.pop_front();
        tests++;
        if (lat != 8 || diff_o[0] !== 8'h0F || {bout_o[0], ovf_o[0], zero_o[0]} !== {e.bo, e.ov, e.z}) begin
            failed++;
            $display("FAIL abort_fresh_op: got lat=%0d diff=%h bout=%b ovf=%b zero=%b, exp lat=8 diff=0f bout=%b ovf=%b zero=%b",
                     lat, diff_o[0], bout_o[0], ovf_o[0], zero_o[0], e.bo, e.ov, e.z);
        end
    endtask

    task automatic test_bpc_sweep();
        exp_t       e;
        int         lat;
        logic [7:0] av;
        logic [7:0] bv;
        logic       bi;
        int         nops;
        for (int sel = 0; sel < 3; sel++) begin
            nops = (sel == 0) ? 100 : 1000;
            for (int n = 0; n < nops; n++) begin
                av = 8'($urandom);
                bv = 8'($urandom);
                bi = 1'($urandom);
                case (n)
                    0: begin av = 8'h00; bv = 8'hFF; bi = 1'b1; end
                    1: begin av = 8'hFF; bv = 8'h00; bi = 1'b0; end
                    2: begin av = 8'h80; bv = 8'h7F; bi = 1'b0; end
                    3: begin av = 8'h00; bv = 8'h00; bi = 1'b0; end
                    default: ;
                endcase
                drive_start(sel, av, bv, bi);
                wait_done(sel, 20, lat);
                tests++;
                if (lat != lat_exp(sel)) begin
                    failed++;
                    $display("FAIL sweep_latency[dut%0d op%0d]: got %0d cycles, exp %0d", sel, n, lat, lat_exp(sel));
                end
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL sweep_scoreboard[dut%0d op%0d]: got empty queue, exp one entry", sel, n);
                end else begin
                    e = sb.pop_front();
                    tests++;
                    if ({diff_o[sel], bout_o[sel], ovf_o[sel], zero_o[sel]} !== {e.d, e.bo, e.ov, e.z}) begin
                        failed++;
                        $display("FAIL sweep_result[dut%0d op%0d a=%h b=%h bin=%b]: got diff=%h bout=%b ovf=%b zero=%b, exp diff=%h bout=%b ovf=%b zero=%b",
                                 sel, n, av, bv, bi, diff_o[sel], bout_o[sel], ovf_o[sel], zero_o[sel], e.d, e.bo, e.ov, e.z);
                    end
                end
                tests++;
                if (busy_o[sel] !== 1'b1 || ready_o[sel] !== 1'b0) begin
                    failed++;
                    $display("FAIL sweep_busy_in_done[dut%0d op%0d]: got busy=%b ready=%b, exp busy=1 ready=0",
                             sel, n, busy_o[sel], ready_o[sel]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        last_d = 8'h00;
        test_reset();
        test_basic();
        test_handshake();
        test_reset_abort();
        test_bpc_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
